// File: rtl/traffic_pkg.sv
// Encodings shared by the country-road sensor conditioner and sig_control.
package traffic_pkg;
  typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} light_t;
  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, SERVING = 2'd2, HOLD = 2'd3} req_state_t;
endpackage

// File: rtl/sensor_debounce.sv
// Synchroniser chain plus consecutive-sample debounce for the loop detector.
module sensor_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic sensor_raw,
  output logic sensor_stable,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync, flip;

  assign sync = sync_q[SYNC_STAGES-1];
  assign flip = (sync != sensor_stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Asserted the cycle before sensor_stable goes 0->1, so the arrival count lands on that same edge.
  assign rise = flip & ~sensor_stable;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_q        <= '0;
      cnt           <= '0;
      sensor_stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
      if (sync == sensor_stable) begin
        cnt <= '0;
      end else if (flip) begin
        cnt           <= '0;
        sensor_stable <= ~sensor_stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/country_sensor_conditioner.sv
// Turns the raw country-road detector into the latched car-present request x,
// with a saturating arrival count for diagnostics.
module country_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               sensor_raw,
  input  logic [1:0]         cntry,
  output logic               x,
  output logic               sensor_stable,
  output logic [COUNT_W-1:0] car_count
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  req_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          rise, stable_d, arrival, green;

  sensor_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock        (clock),
    .clear        (clear),
    .sensor_raw   (sensor_raw),
    .sensor_stable(sensor_stable),
    .rise         (rise)
  );

  assign arrival = sensor_stable & ~stable_d;
  assign green   = (cntry == GREEN);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stable_d  <= 1'b0;
      car_count <= '0;
    end else begin
      stable_d <= sensor_stable;
      if (rise && !(&car_count)) car_count <= car_count + 1'b1;
    end
  end

  // x is set on leaving IDLE and cleared only on re-entering IDLE.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      hold_cnt <= '0;
      x        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arrival) begin
          state <= PENDING;
          x     <= 1'b1;
        end
        PENDING: if (green) begin
          x <= 1'b1;
          if (sensor_stable) begin
            state <= SERVING;
          end else begin
            state    <= HOLD;
            hold_cnt <= HW'(HOLD_CYCLES);
          end
        end
        SERVING: begin
          if (!green) begin
            state <= PENDING;
          end else if (!sensor_stable) begin
            state    <= HOLD;
            hold_cnt <= HW'(HOLD_CYCLES);
          end
        end
        HOLD: begin
          if (!green) begin
            state <= PENDING;
          end else if (arrival) begin
            state <= SERVING;
          end else if (hold_cnt == HW'(1)) begin
            state    <= IDLE;
            hold_cnt <= '0;
            x        <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          x     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Directed bench for country_sensor_conditioner at default parameters.
module tb_country_sensor_conditioner;
  logic       clock, clear, sensor_raw;
  logic [1:0] cntry;
  logic       x, sensor_stable;
  logic [7:0] car_count;

  int ncmp = 0;
  int nfail = 0;

  country_sensor_conditioner dut (
    .clock        (clock),
    .clear        (clear),
    .sensor_raw   (sensor_raw),
    .cntry        (cntry),
    .x            (x),
    .sensor_stable(sensor_stable),
    .car_count    (car_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1; sensor_raw = 1'b0; cntry = 2'd0;
    #3;
    chk("rst_x", x, 0);
    chk("rst_stable", sensor_stable, 0);
    chk("rst_count", car_count, 0);
    #9 clear = 1'b0;
    tick();

    // raw held high: stable on edge 6, x on edge 7
    sensor_raw = 1'b1;
    tick(5);
    chk("stable_e5", sensor_stable, 0);
    tick();
    chk("stable_e6", sensor_stable, 1);
    chk("count_e6", car_count, 1);
    chk("x_e6", x, 0);
    tick();
    chk("x_e7", x, 1);

    // serve, depart, re-arrive inside HOLD: x never drops
    cntry = 2'd2;
    tick();
    chk("x_serving", x, 1);
    sensor_raw = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("x_rearrive", x, 1);
      if (i == 4) sensor_raw = 1'b1;
      if (i == 6) chk("stable_fall", sensor_stable, 0);
      if (i == 10) begin
        chk("stable_rerise", sensor_stable, 1);
        chk("count_rearrive", car_count, 2);
      end
    end

    // departure from SERVING: x falls HOLD_CYCLES+1 edges after stable falls
    sensor_raw = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (j == 5) chk("dep_stable_e5", sensor_stable, 1);
      if (j == 6) chk("dep_stable_e6", sensor_stable, 0);
      if (j == 14) chk("dep_x_e14", x, 1);
      if (j == 15) chk("dep_x_e15", x, 0);
    end

    // 3-cycle pulse and glitch train are rejected
    cntry = 2'd0;
    sensor_raw = 1'b1;
    tick(3);
    sensor_raw = 1'b0;
    tick(10);
    chk("pulse_stable", sensor_stable, 0);
    chk("pulse_x", x, 0);
    chk("pulse_count", car_count, 2);
    for (int k = 0; k < 10; k++) begin
      sensor_raw = ~sensor_raw;
      tick();
    end
    sensor_raw = 1'b0;
    tick(8);
    chk("glitch_stable", sensor_stable, 0);
    chk("glitch_x", x, 0);
    chk("glitch_count", car_count, 2);

    // demand latched through departure while RED, then GREEN -> HOLD -> IDLE
    sensor_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) chk("pend_count", car_count, 3);
      if (i == 7) chk("pend_x", x, 1);
    end
    sensor_raw = 1'b0;
    tick(10);
    chk("pend_stable_low", sensor_stable, 0);
    chk("pend_x_latched", x, 1);
    cntry = 2'd2;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 8) chk("hold_x_e8", x, 1);
      if (i == 9) chk("hold_x_e9", x, 0);
    end

    // saturation of car_count
    cntry = 2'd0;
    for (int k = 1; k <= 300; k++) begin
      sensor_raw = 1'b1;
      tick(8);
      sensor_raw = 1'b0;
      tick(8);
      if (k == 100) chk("count_mid", car_count, 103);
    end
    chk("count_sat", car_count, 255);
    chk("sat_x_pending", x, 1);

    // async clear mid-PENDING
    #3 clear = 1'b1;
    #1;
    chk("clr_x", x, 0);
    chk("clr_count", car_count, 0);
    chk("clr_stable", sensor_stable, 0);
    #2 clear = 1'b0;
    tick(10);
    chk("post_clr_x", x, 0);
    chk("post_clr_count", car_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/country_sensor_conditioner.md
# country_sensor_conditioner

Upstream stage of the highway/country signal controller. Turns the raw, asynchronous, bouncy country-road vehicle detector into the clean, latched car-present request `x` that `sig_control` consumes. It synchronises and debounces the detector and latches demand until the country road has actually been served. It also provides a saturating vehicle-arrival count for diagnostics.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `sensor_raw` (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive disagreeing samples required to flip the debounced level (≥1).
- `HOLD_CYCLES`, 8: cycles `x` stays high after the car leaves during service (≥1).
- `COUNT_W`, 8: width of `car_count`.

Ports:
- `clock` in 1: single system clock, rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `sensor_raw` in 1: raw loop detector, asynchronous to `clock`.
- `cntry` in 2: country-road light state fed back from `sig_control` (RED=0, YELLOW=1, GREEN=2).
- `x` out 1: registered car-present request to `sig_control`.
- `sensor_stable` out 1: debounced detector level.
- `car_count` out COUNT_W: saturating count of debounced rising edges.

## Operation
- Reset (async, `clear`=1): all synchroniser flops 0, debounce counter 0, `sensor_stable`=0, state IDLE, hold counter 0, `x`=0, `car_count`=0. Asserting `clear` mid-cycle drops any pending request at once. No request survives reset.
- Synchroniser: `SYNC_STAGES` flops in series; the last flop gives `sync`.
- Debounce: the counter increments each cycle `sync` ≠ `sensor_stable`. It resets to 0 in any cycle they agree. When it reaches `DEBOUNCE_CYCLES`, `sensor_stable` toggles and the counter returns to 0.
- Arrival: `sensor_stable` 0→1 is an arrival event. Each arrival increments `car_count`, which saturates at all-ones with no wrap.
- Request FSM (state held in registers; `x` is decoded from the registered state):
  - IDLE (`x`=0): on arrival → PENDING.
  - PENDING (`x`=1): demand is latched, and a departure before service does not cancel it. When `cntry`==GREEN, go → SERVING if `sensor_stable`=1, else → HOLD with the hold counter loaded to `HOLD_CYCLES`.
  - SERVING (`x`=1): when `sensor_stable`=0 → HOLD with the counter loaded to `HOLD_CYCLES`.
  - HOLD (`x`=1): the counter decrements each cycle; at 1 → IDLE. An arrival in HOLD → SERVING and counts the car. If arrival and expiry fall in the same cycle, arrival wins.
  - SERVING/HOLD with `cntry`≠GREEN (country lost green unexpectedly): → PENDING. The request persists.
- `cntry`==3 (illegal) is treated as not GREEN.

## Timing
- Raw to stable: with `sensor_raw` held, `sensor_stable` changes on edge `SYNC_STAGES`+`DEBOUNCE_CYCLES` after the first sampling edge. Default: edge 6.
- Stable to `x`: `x` rises one edge after `sensor_stable` rises from IDLE. Default: edge 7 after the raw edge.
- Glitch rejection: raw pulses shorter than `DEBOUNCE_CYCLES` cycles, as seen at `sync`, never change `sensor_stable`, `car_count` or `x`.
- After departure in SERVING, `x` falls exactly `HOLD_CYCLES`+1 edges after `sensor_stable` falls.
- `car_count` updates on the same edge `sensor_stable` rises.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Shared `traffic_pkg`:
  - light encodings RED/YELLOW/GREEN (also used by `sig_control`);
  - request-state encodings IDLE=0, PENDING=1, SERVING=2, HOLD=3.
- Sub-module `sensor_debounce`: synchroniser plus debounce counter, parameterised by `SYNC_STAGES` and `DEBOUNCE_CYCLES`, producing `sensor_stable`.
- The top level holds the arrival-edge detect, the counter, the FSM and the hold counter.
- Counter widths: debounce uses `$clog2(DEBOUNCE_CYCLES+1)`, hold uses `$clog2(HOLD_CYCLES+1)`.

## Test plan
- Reset, then raw=1 held (defaults) → `sensor_stable`=1 at edge 6, `x`=1 at edge 7, `car_count`=1.
- Raw 3-cycle pulse and a 1-cycle glitch train → `sensor_stable`, `x` and `car_count` stay 0.
- Raw=1 for 10 cycles then 0 while `cntry`=RED → `x` stays 1 (PENDING). Drive `cntry`=GREEN → HOLD. `x` falls 9 edges later.
- In SERVING, raw falls, then re-rises 3 cycles into HOLD → back to SERVING, `car_count` increments, `x` never drops.
- 300 debounced arrivals (COUNT_W=8) → `car_count` stops at 255.
- `clear` pulsed mid-PENDING → `x`=0 and `car_count`=0 immediately, asynchronously. After release with raw=0, `x` stays 0.
